generation_sequencer: RTL and testbench
=======================================

# generation_sequencer

Controls when the Life engine advances one generation. Consumes the slow square wave from the clock divider and the debounced user controls (run/pause, single step, clear). Issues one-at-a-time step or clear requests to the grid update engine over a req/ack handshake. Counts completed generations and flags ticks that arrive while the engine is still busy.

## Interface
- GEN_WIDTH, 16, width of the generation counter
- SYNC_STAGES, 2, flip-flops in the tick_in synchronizer (≥2)

- clock_in  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- tick_in  in  1  divided square wave; treated as asynchronous, synchronized internally
- run_toggle  in  1  one-cycle pulse; toggles run/pause
- step_btn  in  1  one-cycle pulse; single-step request, honoured only while paused
- clear_btn  in  1  one-cycle pulse; grid-clear request
- step_ack  in  1  engine completion; one-cycle or level, sampled only while a request is outstanding
- step_req  out  1  high while a generation step is outstanding
- clear_req  out  1  high while a clear is outstanding
- running  out  1  1 = auto-advance on ticks, 0 = paused
- busy  out  1  high whenever step_req or clear_req is high
- generation  out  GEN_WIDTH  completed generations since the last clear
- overrun  out  1  sticky; a tick arrived while busy and running

## Operation
- Synchronizer: tick_in passes through SYNC_STAGES flops, then one edge register. tick_rise = last sync stage & ~edge register.
- FSM states: IDLE, STEP, CLEAR. busy = (state != IDLE). step_req = (state == STEP). clear_req = (state == CLEAR). All are registered.
- IDLE priority, highest first:
  - clear_btn or clear_pending → CLEAR; clear_pending is cleared.
  - running & tick_rise → STEP.
  - !running & step_btn → STEP.
  - Otherwise stay in IDLE.
- STEP: on step_ack = 1 → IDLE; generation <= generation + 1, wrapping modulo 2^GEN_WIDTH (all-ones → 0).
- CLEAR: on step_ack = 1 → IDLE; generation <= 0, overrun <= 0, running <= 0. A clear always leaves the design paused.
- run_toggle is honoured in every state. It flips running and never aborts an outstanding request.
  - If run_toggle and a clear-ack occur in the same cycle, the clear wins and running = 0.
- While busy:
  - clear_btn sets clear_pending; it is issued on the next IDLE cycle.
  - step_btn is dropped.
  - tick_rise with running = 1 sets overrun and the tick is dropped. Ticks are never queued.
- step_ack while IDLE is ignored.
- If step_btn and tick_rise coincide, at most one STEP is issued.

## Timing
- Reset asserted, asynchronously: state = IDLE; all outputs, synchronizer, edge register and clear_pending = 0.
- Reset mid-request drops step_req/clear_req immediately; no acknowledgement is expected afterwards.
- Because the sync chain resets to 0, a tick_in held high through reset release produces one tick_rise SYNC_STAGES cycles later. It is ignored, since running = 0.
- Tick latency: tick_in first sampled high at edge k → step_req high after edge k+SYNC_STAGES, if IDLE and running.
- Button latency: step_btn or clear_btn high at edge k in IDLE → request high after edge k.
- Handshake: the request stays high until step_ack is sampled at edge m. The request is low and the counter updated after edge m.
- The earliest following request is after edge m+1, so there is at least one IDLE cycle between requests.
- tick_in must have a period greater than 2·(SYNC_STAGES+1) clock cycles; shorter periods are unsupported.

## Test plan
- Reset and pause:
  - Stimulus: release reset with tick_in = 1, toggling with period 20 clocks; no buttons.
  - Required: all outputs stay 0 and step_req never rises.
- Single step:
  - Stimulus: paused; step_btn pulse at edge 10; ack the third cycle after the request.
  - Required: step_req high edges 10–13, generation = 1 after edge 13, busy low after 13.
  - Stimulus: step_btn again at edge 15. Required: generation = 2 after the ack.
- Auto-run:
  - Stimulus: run_toggle, then 5 tick_in periods; the engine acks in 1 cycle.
  - Required: exactly 5 requests, each starting SYNC_STAGES edges after tick_in rises; generation = 5; overrun = 0.
- Overrun:
  - Stimulus: running; hold ack off for 30 cycles across one tick_in rising edge.
  - Required: overrun = 1 and stays set after the ack; only one step is counted.
- Clear during step:
  - Stimulus: clear_btn while step_req is high, then ack; the next cycle issues clear_req; ack it.
  - Required: generation = 1 then 0, overrun = 0, running = 0.
- Wrap:
  - Stimulus: GEN_WIDTH = 4; 17 paused single steps.
  - Required: generation reads 15 after step 15, 0 after step 16, 1 after step 17.

Source files
------------

// File: rtl/generation_sequencer.sv
// generation_sequencer
// Decides when the Life engine advances one generation. A divided square
// wave (tick_in) is synchronized and edge-detected; while running, each
// rising edge requests one step. While paused, step_btn requests a single
// step. clear_btn requests a grid clear, which also zeroes the counter and
// pauses. Only one request is outstanding at a time (req/ack handshake).
//
// Ports:
//   clock_in   - system clock, rising edge
//   reset      - asynchronous active-low reset
//   tick_in    - asynchronous divided square wave
//   run_toggle - one-cycle pulse, flips run/pause
//   step_btn   - one-cycle pulse, single step (honoured only while paused)
//   clear_btn  - one-cycle pulse, grid clear (deferred if busy)
//   step_ack   - engine completion, sampled only while a request is out
//   step_req   - step outstanding
//   clear_req  - clear outstanding
//   running    - 1 = auto-advance on ticks
//   busy       - step_req | clear_req
//   generation - completed generations since the last clear (wrapping)
//   overrun    - sticky: a tick arrived while busy and running
module generation_sequencer #(
    parameter int GEN_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clock_in,
    input  logic                 reset,
    input  logic                 tick_in,
    input  logic                 run_toggle,
    input  logic                 step_btn,
    input  logic                 clear_btn,
    input  logic                 step_ack,
    output logic                 step_req,
    output logic                 clear_req,
    output logic                 running,
    output logic                 busy,
    output logic [GEN_WIDTH-1:0] generation,
    output logic                 overrun
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_STEP  = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    localparam logic [GEN_WIDTH-1:0] GEN_ZERO = {GEN_WIDTH{1'b0}};
    localparam logic [GEN_WIDTH-1:0] GEN_ONE  = {{(GEN_WIDTH-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   edge_q;
    logic                   tick_rise_s;

    logic [1:0]             state_q, state_d;
    logic [GEN_WIDTH-1:0]   gen_q, gen_d;
    logic                   running_q, running_d;
    logic                   overrun_q, overrun_d;
    logic                   pend_q, pend_d;
    logic                   step_req_q, clear_req_q, busy_q;

    // Synchronizer shift and rising-edge detect on the last stage.
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], tick_in};
        tick_rise_s = sync_q[SYNC_STAGES-1] & ~edge_q;
    end

    // Next-state logic for the request FSM, counter and status flags.
    always_comb begin
        state_d   = state_q;
        gen_d     = gen_q;
        running_d = running_q ^ run_toggle;
        overrun_d = overrun_q;
        pend_d    = pend_q;

        // While a request is out: remember clears, flag (and drop) ticks.
        if (state_q != ST_IDLE) begin
            if (clear_btn) begin
                pend_d = 1'b1;
            end else begin
                pend_d = pend_q;
            end
            if (running_q && tick_rise_s) begin
                overrun_d = 1'b1;
            end else begin
                overrun_d = overrun_q;
            end
        end else begin
            pend_d    = pend_q;
            overrun_d = overrun_q;
        end

        case (state_q)
            ST_IDLE: begin
                // A step_btn coinciding with a tick can only start one STEP.
                if (clear_btn || pend_q) begin
                    state_d = ST_CLEAR;
                    pend_d  = 1'b0;
                end else if (running_q && tick_rise_s) begin
                    state_d = ST_STEP;
                end else if (!running_q && step_btn) begin
                    state_d = ST_STEP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: begin
                if (step_ack) begin
                    state_d = ST_IDLE;
                    gen_d   = gen_q + GEN_ONE;
                end else begin
                    state_d = ST_STEP;
                end
            end
            ST_CLEAR: begin
                // A clear always leaves the design paused, even against a
                // simultaneous run_toggle.
                if (step_ack) begin
                    state_d   = ST_IDLE;
                    gen_d     = GEN_ZERO;
                    overrun_d = 1'b0;
                    running_d = 1'b0;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, synchronizer and registered outputs.
    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            sync_q      <= {SYNC_STAGES{1'b0}};
            edge_q      <= 1'b0;
            state_q     <= ST_IDLE;
            gen_q       <= GEN_ZERO;
            running_q   <= 1'b0;
            overrun_q   <= 1'b0;
            pend_q      <= 1'b0;
            step_req_q  <= 1'b0;
            clear_req_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            edge_q      <= sync_q[SYNC_STAGES-1];
            state_q     <= state_d;
            gen_q       <= gen_d;
            running_q   <= running_d;
            overrun_q   <= overrun_d;
            pend_q      <= pend_d;
            step_req_q  <= (state_d == ST_STEP);
            clear_req_q <= (state_d == ST_CLEAR);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign step_req   = step_req_q;
    assign clear_req  = clear_req_q;
    assign busy       = busy_q;
    assign running    = running_q;
    assign overrun    = overrun_q;
    assign generation = gen_q;

endmodule

// File: tb/tb_generation_sequencer.sv
// Directed testbench for generation_sequencer (GEN_WIDTH = 4 so the
// wrap-around is reachable). Inputs change 1 time unit after a rising
// edge; outputs are sampled at that same point.
module tb_generation_sequencer;

    localparam int GW = 4;
    localparam int SS = 2;

    logic          clk;
    logic          rst_n;
    logic          tick_in, run_toggle, step_btn, clear_btn, step_ack;
    logic          step_req, clear_req, running, busy, overrun;
    logic [GW-1:0] generation;

    int n_checks;
    int n_errors;
    int cyc;

    generation_sequencer #(.GEN_WIDTH(GW), .SYNC_STAGES(SS)) dut (
        .clock_in   (clk),
        .reset      (rst_n),
        .tick_in    (tick_in),
        .run_toggle (run_toggle),
        .step_btn   (step_btn),
        .clear_btn  (clear_btn),
        .step_ack   (step_ack),
        .step_req   (step_req),
        .clear_req  (clear_req),
        .running    (running),
        .busy       (busy),
        .generation (generation),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step_cycle();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        run_toggle = 1'b0; step_btn = 1'b0; clear_btn = 1'b0; step_ack = 1'b0;
        #1;
        check_eq("rst_outs", {26'd0, step_req, clear_req, running, busy, overrun, 1'b0}, 32'd0);
        check_eq("rst_gen", {28'd0, generation}, 32'd0);
        step_cycle();
        step_cycle();
        rst_n = 1'b1;
    endtask

    // One paused single step with a one-cycle ack, plus an idle gap.
    task automatic single_step();
        step_btn = 1'b1;
        step_cycle();
        step_btn = 1'b0;
        step_ack = 1'b1;
        step_cycle();
        step_ack = 1'b0;
        step_cycle();
    endtask

    initial begin
        logic seen_req;
        logic prev_req;
        int   t0;
        int   nreq;

        n_checks = 0; n_errors = 0; cyc = 0;
        tick_in = 1'b1;
        rst_n = 1'b1;

        // ---- Reset with tick_in high, then free-running ticks: paused
        do_reset();
        seen_req = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick_in = ((i % 20) < 10) ? 1'b1 : 1'b0;
            step_cycle();
            if (step_req || busy) seen_req = 1'b1;
        end
        check_eq("pause_noreq", {31'd0, seen_req}, 32'd0);
        check_eq("pause_flags", {29'd0, running, overrun, clear_req}, 32'd0);
        check_eq("pause_gen", {28'd0, generation}, 32'd0);

        // ---- Single step, ack third cycle after the request
        tick_in = 1'b0;
        do_reset();
        step_cycle();
        step_ack = 1'b1;                      // ack while IDLE is ignored
        step_cycle();
        step_ack = 1'b0;
        check_eq("idle_ack_gen", {28'd0, generation}, 32'd0);
        check_eq("idle_ack_req", {31'd0, step_req}, 32'd0);
        step_btn = 1'b1;
        step_cycle();
        step_btn = 1'b0;
        check_eq("ss_req_k", {30'd0, step_req, busy}, 32'd3);
        step_cycle();
        check_eq("ss_req_k1", {31'd0, step_req}, 32'd1);
        step_btn = 1'b1;                      // dropped while busy
        step_cycle();
        step_btn = 1'b0;
        check_eq("ss_req_k2", {31'd0, step_req}, 32'd1);
        step_ack = 1'b1;
        step_cycle();
        step_ack = 1'b0;
        check_eq("ss_done", {27'd0, step_req, busy, generation}, {27'd0, 2'b00, 4'd1});
        step_cycle();
        check_eq("ss_drop_btn", {31'd0, step_req}, 32'd0);
        single_step();
        check_eq("ss_gen2", {28'd0, generation}, 32'd2);

        // ---- Auto-run: 5 tick periods, 1-cycle ack
        do_reset();
        run_toggle = 1'b1;
        step_cycle();
        run_toggle = 1'b0;
        check_eq("run_on", {31'd0, running}, 32'd1);
        step_btn = 1'b1;                      // ignored while running
        step_cycle();
        step_btn = 1'b0;
        step_cycle();
        check_eq("run_btn_ign", {31'd0, step_req}, 32'd0);
        nreq = 0;
        prev_req = 1'b0;
        t0 = 0;
        for (int p = 0; p < 5; p++) begin
            for (int j = 0; j < 20; j++) begin
                if (j == 0) begin
                    tick_in = 1'b1;
                    t0 = cyc;
                end
                if (j == 10) tick_in = 1'b0;
                step_ack = step_req;
                step_cycle();
                if (step_req && !prev_req) begin
                    nreq = nreq + 1;
                    check_eq("tick_latency", cyc - t0, SS + 1);
                end
                prev_req = step_req;
            end
        end
        step_ack = 1'b0;
        check_eq("run_nreq", nreq, 32'd5);
        check_eq("run_gen", {28'd0, generation}, 32'd5);
        check_eq("run_ovr", {31'd0, overrun}, 32'd0);

        // ---- Overrun: ack held off ~30 cycles across a second tick rise
        for (int j = 0; j < 45; j++) begin
            if (j == 0)  tick_in = 1'b1;
            if (j == 10) tick_in = 1'b0;
            if (j == 20) tick_in = 1'b1;
            if (j == 30) tick_in = 1'b0;
            step_ack = (j == 32) ? 1'b1 : 1'b0;
            step_cycle();
            if (j == 28) check_eq("ovr_busy", {30'd0, step_req, overrun}, 32'd3);
        end
        check_eq("ovr_sticky", {31'd0, overrun}, 32'd1);
        check_eq("ovr_gen", {28'd0, generation}, 32'd6);
        check_eq("ovr_idle", {31'd0, busy}, 32'd0);

        // ---- Clear during a step; run_toggle honoured while busy
        tick_in = 1'b1;
        step_cycle();
        step_cycle();
        step_cycle();
        check_eq("clr_step_up", {31'd0, step_req}, 32'd1);
        clear_btn = 1'b1;
        step_cycle();
        clear_btn = 1'b0;
        check_eq("clr_deferred", {30'd0, step_req, clear_req}, 32'd2);
        step_ack = 1'b1;
        step_cycle();
        step_ack = 1'b0;
        check_eq("clr_gap", {29'd0, step_req, clear_req, busy}, 32'd0);
        check_eq("clr_gen_pre", {28'd0, generation}, 32'd7);
        step_cycle();
        check_eq("clr_issued", {30'd0, clear_req, busy}, 32'd3);
        tick_in = 1'b0;
        run_toggle = 1'b1;
        step_cycle();
        run_toggle = 1'b0;
        check_eq("clr_toggle", {30'd0, running, clear_req}, 32'd1);
        step_ack = 1'b1;
        run_toggle = 1'b1;                    // clear-ack wins: stays paused
        step_cycle();
        step_ack = 1'b0;
        run_toggle = 1'b0;
        check_eq("clr_done", {26'd0, running, overrun, clear_req, busy, generation[1:0]}, 32'd0);
        check_eq("clr_gen0", {28'd0, generation}, 32'd0);

        // ---- Reset mid-request drops the request immediately
        step_btn = 1'b1;
        step_cycle();
        step_btn = 1'b0;
        check_eq("mid_req_up", {31'd0, step_req}, 32'd1);
        do_reset();

        // ---- Wrap: 17 paused single steps at GEN_WIDTH = 4
        for (int i = 0; i < 17; i++) begin
            single_step();
            check_eq("wrap_gen", {28'd0, generation}, (i + 1) % 16);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
